// File: rtl/pwm_audio_out.sv
// pwm_audio_out
//   Buffered PWM audio output stage. Samples are pushed into a small FIFO and
//   one sample is consumed per PWM period (2^SAMPLE_WIDTH clock cycles). The
//   sample in use sets the number of cycles per period that aud_pwm is high.
//
//   Parameters:
//     CPU_CLOCK_FREQ - informational clock rate, for software sample-rate math
//     SAMPLE_WIDTH   - PWM resolution in bits, period = 2^SAMPLE_WIDTH cycles
//     FIFO_DEPTH     - sample buffer entries (power of two, >= 2)
//
//   Ports:
//     clk            - sole clock, rising edge
//     rst_n          - synchronous active-low reset
//     enable         - playback enable (cnt held at 0 and no pops while low)
//     in_data        - unsigned duty sample
//     in_valid       - in_data valid
//     in_ready       - FIFO can accept (depends only on occupancy)
//     fifo_count     - current FIFO occupancy
//     aud_pwm        - registered PWM output
//     aud_sd         - amplifier shutdown-bar, registered copy of enable
//     underrun_count - saturating count of wraps with an empty FIFO
//                      (only with PWM_AUDIO_UNDERRUN_COUNT_EN defined)
//
//   Optional feature macro: PWM_AUDIO_UNDERRUN_COUNT_EN

module pwm_audio_out #(
  parameter int CPU_CLOCK_FREQ = 90_000_000,
  parameter int SAMPLE_WIDTH   = 10,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [SAMPLE_WIDTH-1:0]       in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          aud_pwm,
  output logic                          aud_sd
`ifdef PWM_AUDIO_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]                   underrun_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [SAMPLE_WIDTH-1:0] cnt;
  logic [SAMPLE_WIDTH-1:0] duty;

  logic fifo_empty;
  logic wrap;
  logic push;
  logic pop;

  // in_ready looks only at occupancy, so a full FIFO refuses a push even on
  // the cycle a pop frees an entry.
  always_comb begin
    in_ready   = (fifo_count != CW'(FIFO_DEPTH));
    fifo_empty = (fifo_count == '0);
    wrap       = enable && (cnt == '1);
    push       = in_valid && in_ready;
    pop        = wrap && !fifo_empty;
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally at FIFO_DEPTH
  // because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Period counter, duty register and registered outputs. The pop happens on
  // the last cycle of a period so the new duty is in place when cnt is 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      duty    <= '0;
      aud_pwm <= 1'b0;
      aud_sd  <= 1'b0;
    end else begin
      cnt     <= enable ? cnt + SAMPLE_WIDTH'(1) : '0;
      if (pop) duty <= mem[rd_ptr];
      aud_pwm <= enable && (cnt < duty);
      aud_sd  <= enable;
    end
  end

`ifdef PWM_AUDIO_UNDERRUN_COUNT_EN
  logic underrun;

  always_comb begin
    underrun = wrap && fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != '1)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out
//   Self-checking bench for pwm_audio_out with SAMPLE_WIDTH=4, FIFO_DEPTH=8
//   (16-cycle PWM period). A behavioural model (sample queue, period position,
//   current duty) predicts every output after each clock; directed scenarios
//   add period-level high-cycle counts, then a randomized phase follows.

module tb_pwm_audio_out;

  localparam int SW     = 4;
  localparam int DEPTH  = 8;
  localparam int PERIOD = 16;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [SW-1:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  fifo_count;
  logic        aud_pwm;
  logic        aud_sd;
`ifdef PWM_AUDIO_UNDERRUN_COUNT_EN
  logic [15:0] underrun_count;
`endif

  pwm_audio_out #(
    .SAMPLE_WIDTH (SW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .fifo_count     (fifo_count),
    .aud_pwm        (aud_pwm),
    .aud_sd         (aud_sd)
`ifdef PWM_AUDIO_UNDERRUN_COUNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int q[$];
  int m_pos   = 0;   // position within the current PWM period
  int m_duty  = 0;   // sample governing the current period
  bit m_pwm   = 0;
  bit m_sd    = 0;
  int m_under = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs presented at that edge.
  function automatic void model_step();
    int  pre_size;
    bit  period_end;
    if (!rst_n) begin
      q.delete();
      m_pos   = 0;
      m_duty  = 0;
      m_pwm   = 0;
      m_sd    = 0;
      m_under = 0;
      return;
    end
    pre_size   = q.size();
    m_pwm      = enable && (m_pos < m_duty);
    m_sd       = enable;
    period_end = enable && (m_pos == PERIOD - 1);
    if (period_end) begin
      if (pre_size > 0) m_duty = q.pop_front();
      else if (m_under < 65535) m_under++;
    end
    if (in_valid && pre_size < DEPTH) q.push_back(int'(in_data));
    m_pos = enable ? (m_pos + 1) % PERIOD : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("aud_pwm", aud_pwm, m_pwm);
    check("aud_sd", aud_sd, m_sd);
    check("fifo_count", fifo_count, q.size());
    check("in_ready", in_ready, q.size() != DEPTH);
`ifdef PWM_AUDIO_UNDERRUN_COUNT_EN
    check("underrun_count", underrun_count, m_under);
`endif
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_one(input int value);
    in_valid = 1'b1;
    in_data  = SW'(value);
    tick();
    in_valid = 1'b0;
  endtask

  // Sample one full period of aud_pwm and return how many cycles were high.
  task automatic count_period(output int highs);
    highs = 0;
    repeat (PERIOD) begin
      tick();
      highs += int'(aud_pwm);
    end
  endtask

  int highs;

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;

    // Reset state
    do_reset();
    check("reset_pwm", aud_pwm, 0);
    check("reset_sd", aud_sd, 0);
    check("reset_count", fifo_count, 0);
    check("reset_ready", in_ready, 1);

    // Duty 12: after the first wrap each period is 12 high, 4 low
    push_one(12);
    enable = 1'b1;
    repeat (PERIOD) tick();
    for (int p = 0; p < 3; p++) begin
      count_period(highs);
      check("duty12_highs", highs, 12);
    end

    // Reset mid-playback with three samples buffered
    push_one(3);
    push_one(6);
    push_one(9);
    tick();
    check("pre_reset_count", fifo_count, 3);
    rst_n = 1'b0;
    tick();
    tick();
    check("midrst_pwm", aud_pwm, 0);
    check("midrst_sd", aud_sd, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_ready", in_ready, 1);
    rst_n = 1'b1;
    count_period(highs);
    check("post_reset_duty0", highs, 0);

    // Full FIFO: ninth sample refused and never played
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_data = SW'(i);
      tick();
      if (i == 8) begin
        check("full_ready", in_ready, 0);
        check("full_count", fifo_count, 8);
      end
    end
    in_valid = 1'b0;
    check("full_count_after9", fifo_count, 8);
    enable = 1'b1;
    repeat (PERIOD) tick();
    for (int p = 0; p < 9; p++) begin
      count_period(highs);
      check("full_playback_highs", highs, (p < 8) ? p + 1 : 8);
    end

    // Underrun: a single sample of 5 held for every period
    do_reset();
    push_one(5);
    enable = 1'b1;
    repeat (PERIOD) tick();
    for (int p = 0; p < 3; p++) begin
      count_period(highs);
      check("underrun_highs", highs, 5);
    end
`ifdef PWM_AUDIO_UNDERRUN_COUNT_EN
    check("underrun_total", underrun_count, 3);
`endif

    // Boundaries: duty 0 then 15, with a simultaneous push and pop at wrap
    do_reset();
    push_one(0);
    push_one(15);
    enable = 1'b1;
    repeat (PERIOD - 1) tick();
    push_one(7);
    check("push_pop_count", fifo_count, 2);
    count_period(highs);
    check("duty0_highs", highs, 0);
    count_period(highs);
    check("duty15_highs", highs, 15);
    count_period(highs);
    check("duty7_highs", highs, 7);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 599) != 0);
      enable   = ($urandom_range(0, 39) != 0);
      in_valid = ($urandom_range(0, 9) == 0);
      in_data  = SW'($urandom);
      tick();
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
